// File: rtl/nav_alu_pipe.sv
// nav_alu_pipe: two-stage pipelined navigation ALU.
//   S1 captures opcode, operands, obstacle-row inputs and the velocity-guard
//   status; S2 computes the result, flags and the illegal indication.
//   Both stages advance together and freeze while the output is stalled.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   upstream handshake; in_ready = !(out_valid && !out_ready)
//   opcode, a, b        operation and WIDTH-bit operands
//   car_x, img_row      car column and obstacle bitmap (1 = blocked)
//   velocity_en         velocity permit, sampled every cycle
//   out_valid/out_ready downstream handshake
//   result              WIDTH-bit result
//   zero/negative/carry/overflow_flag  flags of result
//   illegal             undefined opcode or car_x out of range
module nav_alu_pipe #(
  parameter int WIDTH  = 16,
  parameter int ROW_W  = 16,
  parameter int MARGIN = 1,
  parameter int HOLD   = 4,
  localparam int XW    = $clog2(ROW_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        opcode,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [XW-1:0]     car_x,
  input  logic [ROW_W-1:0]  img_row,
  input  logic              velocity_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              zero_flag,
  output logic              negative_flag,
  output logic              carry_flag,
  output logic              overflow_flag,
  output logic              illegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(HOLD + 1);

  localparam logic [4:0] OP_MOV      = 5'b00000;
  localparam logic [4:0] OP_LD       = 5'b00001;
  localparam logic [4:0] OP_ST       = 5'b00010;
  localparam logic [4:0] OP_ADD      = 5'b00011;
  localparam logic [4:0] OP_SUB      = 5'b00100;
  localparam logic [4:0] OP_AND      = 5'b00101;
  localparam logic [4:0] OP_OR       = 5'b00110;
  localparam logic [4:0] OP_NOT      = 5'b00111;
  localparam logic [4:0] OP_JMP      = 5'b01000;
  localparam logic [4:0] OP_NOP      = 5'b01001;
  localparam logic [4:0] OP_OB_CHECK = 5'b01010;
  localparam logic [4:0] OP_LEFT     = 5'b01011;
  localparam logic [4:0] OP_RIGHT    = 5'b01100;
  localparam logic [4:0] OP_STOP     = 5'b01101;
  localparam logic [4:0] OP_CONT     = 5'b01110;
  localparam logic [4:0] OP_VGUARD   = 5'b01111;
  localparam logic [4:0] OP_SHL      = 5'b10000;
  localparam logic [4:0] OP_SHR      = 5'b10001;
  localparam logic [4:0] OP_CMP      = 5'b10010;

  localparam logic [1:0] ACT_STOP  = 2'd0;
  localparam logic [1:0] ACT_LEFT  = 2'd1;
  localparam logic [1:0] ACT_RIGHT = 2'd2;
  localparam logic [1:0] ACT_CONT  = 2'd3;

  // Returns {illegal, action}. Iterating over every column with constant
  // indices keeps the window clamp and the neighbour tests free of
  // out-of-range selects: a neighbour outside the row simply never matches.
  function automatic logic [2:0] ob_check(input logic [ROW_W-1:0] row,
                                          input logic [XW-1:0]    cx_in);
    int   cx;
    logic hazard;
    logic left_free;
    logic right_free;
    cx         = int'(cx_in);
    hazard     = 1'b0;
    left_free  = 1'b0;
    right_free = 1'b0;
    for (int i = 0; i < ROW_W; i++) begin
      if (row[i] && (i >= cx - MARGIN) && (i <= cx + MARGIN)) hazard = 1'b1;
      if (i == cx - 1) left_free  = !row[i];
      if (i == cx + 1) right_free = !row[i];
    end
    if (cx >= ROW_W)  return {1'b1, ACT_STOP};
    if (!hazard)      return {1'b0, ACT_CONT};
    if (left_free)    return {1'b0, ACT_LEFT};
    if (right_free)   return {1'b0, ACT_RIGHT};
    return {1'b0, ACT_STOP};
  endfunction

  function automatic logic [WIDTH-1:0] act_ext(input logic [1:0] act);
    return {{(WIDTH-2){1'b0}}, act};
  endfunction

  logic stall;

  logic [CW-1:0]    hold_cnt_q, hold_cnt_d;

  logic             vld_p1_q, vld_p1_d;
  logic [4:0]       op_p1_q, op_p1_d;
  logic [WIDTH-1:0] a_p1_q, a_p1_d;
  logic [WIDTH-1:0] b_p1_q, b_p1_d;
  logic [XW-1:0]    carx_p1_q, carx_p1_d;
  logic [ROW_W-1:0] row_p1_q, row_p1_d;
  logic             guard_ok_p1_q, guard_ok_p1_d;

  logic             vld_p2_q, vld_p2_d;
  logic [WIDTH-1:0] res_p2_q, res_p2_d;
  logic             zf_p2_q, zf_p2_d;
  logic             nf_p2_q, nf_p2_d;
  logic             cf_p2_q, cf_p2_d;
  logic             vf_p2_q, vf_p2_d;
  logic             ill_p2_q, ill_p2_d;

  logic [WIDTH-1:0] res_c;
  logic             cf_c, vf_c, ill_c, flags_on_c;
  logic [WIDTH:0]   sum_c, dif_c;
  logic [2:0]       ob_c;

  assign stall    = vld_p2_q && !out_ready;
  assign in_ready = !stall;

  // Guard counter runs every cycle regardless of the pipeline state.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (!velocity_en)                  hold_cnt_d = '0;
    else if (hold_cnt_q != CW'(HOLD))  hold_cnt_d = hold_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_cnt_q <= '0;
    else     hold_cnt_q <= hold_cnt_d;
  end

  // ---- S1: capture the accepted operation ----
  always_comb begin
    vld_p1_d      = stall ? vld_p1_q : in_valid;
    op_p1_d       = op_p1_q;
    a_p1_d        = a_p1_q;
    b_p1_d        = b_p1_q;
    carx_p1_d     = carx_p1_q;
    row_p1_d      = row_p1_q;
    guard_ok_p1_d = guard_ok_p1_q;
    if (!stall && in_valid) begin
      op_p1_d       = opcode;
      a_p1_d        = a;
      b_p1_d        = b;
      carx_p1_d     = car_x;
      row_p1_d      = img_row;
      guard_ok_p1_d = (hold_cnt_q == CW'(HOLD));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1_q <= 1'b0;
    else     vld_p1_q <= vld_p1_d;
  end

  always_ff @(posedge clk) begin
    op_p1_q       <= op_p1_d;
    a_p1_q        <= a_p1_d;
    b_p1_q        <= b_p1_d;
    carx_p1_q     <= carx_p1_d;
    row_p1_q      <= row_p1_d;
    guard_ok_p1_q <= guard_ok_p1_d;
  end

  // ---- S2: execute and register result, flags, illegal ----
  always_comb begin
    sum_c      = {1'b0, a_p1_q} + {1'b0, b_p1_q};
    dif_c      = {1'b0, a_p1_q} - {1'b0, b_p1_q};
    ob_c       = ob_check(row_p1_q, carx_p1_q);
    res_c      = '0;
    cf_c       = 1'b0;
    vf_c       = 1'b0;
    ill_c      = 1'b0;
    flags_on_c = 1'b1;
    case (op_p1_q)
      OP_MOV, OP_LD, OP_ST: res_c = b_p1_q;
      OP_ADD: begin
        res_c = sum_c[WIDTH-1:0];
        cf_c  = sum_c[WIDTH];
        vf_c  = (a_p1_q[WIDTH-1] == b_p1_q[WIDTH-1]) &&
                (sum_c[WIDTH-1] != a_p1_q[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        res_c = dif_c[WIDTH-1:0];
        cf_c  = dif_c[WIDTH];  // borrow out == (a < b) unsigned
        vf_c  = (a_p1_q[WIDTH-1] != b_p1_q[WIDTH-1]) &&
                (dif_c[WIDTH-1] != a_p1_q[WIDTH-1]);
      end
      OP_AND:      res_c = a_p1_q & b_p1_q;
      OP_OR:       res_c = a_p1_q | b_p1_q;
      OP_NOT:      res_c = ~a_p1_q;
      OP_JMP:      res_c = a_p1_q;
      OP_NOP:      res_c = '0;
      OP_SHL:      res_c = a_p1_q << b_p1_q[SHW-1:0];
      OP_SHR:      res_c = a_p1_q >> b_p1_q[SHW-1:0];
      OP_LEFT:     res_c = act_ext(ACT_LEFT);
      OP_RIGHT:    res_c = act_ext(ACT_RIGHT);
      OP_STOP:     res_c = act_ext(ACT_STOP);
      OP_CONT:     res_c = act_ext(ACT_CONT);
      OP_OB_CHECK: begin
        res_c = act_ext(ob_c[1:0]);
        ill_c = ob_c[2];
      end
      OP_VGUARD:   res_c = act_ext(guard_ok_p1_q ? ACT_CONT : ACT_STOP);
      default: begin
        // Undefined ops still flow through, but with every flag forced low.
        ill_c      = 1'b1;
        flags_on_c = 1'b0;
      end
    endcase

    vld_p2_d = stall ? vld_p2_q : vld_p1_q;
    res_p2_d = res_p2_q;
    zf_p2_d  = zf_p2_q;
    nf_p2_d  = nf_p2_q;
    cf_p2_d  = cf_p2_q;
    vf_p2_d  = vf_p2_q;
    ill_p2_d = ill_p2_q;
    if (!stall && vld_p1_q) begin
      res_p2_d = res_c;
      zf_p2_d  = flags_on_c && (res_c == '0);
      nf_p2_d  = flags_on_c && res_c[WIDTH-1];
      cf_p2_d  = cf_c;
      vf_p2_d  = vf_c;
      ill_p2_d = ill_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2_q <= 1'b0;
      res_p2_q <= '0;
      zf_p2_q  <= 1'b0;
      nf_p2_q  <= 1'b0;
      cf_p2_q  <= 1'b0;
      vf_p2_q  <= 1'b0;
      ill_p2_q <= 1'b0;
    end else begin
      vld_p2_q <= vld_p2_d;
      res_p2_q <= res_p2_d;
      zf_p2_q  <= zf_p2_d;
      nf_p2_q  <= nf_p2_d;
      cf_p2_q  <= cf_p2_d;
      vf_p2_q  <= vf_p2_d;
      ill_p2_q <= ill_p2_d;
    end
  end

  assign out_valid     = vld_p2_q;
  assign result        = res_p2_q;
  assign zero_flag     = zf_p2_q;
  assign negative_flag = nf_p2_q;
  assign carry_flag    = cf_p2_q;
  assign overflow_flag = vf_p2_q;
  assign illegal       = ill_p2_q;

endmodule

// File: tb/tb_nav_alu_pipe.sv
// Scoreboard bench for nav_alu_pipe (WIDTH=16, ROW_W=16, MARGIN=1, HOLD=4).
// Driver pushes hand-computed expectations; a monitor pops them on each
// output transfer.
module tb_nav_alu_pipe;
  localparam int WIDTH = 16;
  localparam int ROW_W = 16;
  localparam int XW    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [4:0]       opcode;
  logic [WIDTH-1:0] a, b;
  logic [XW-1:0]    car_x;
  logic [ROW_W-1:0] img_row;
  logic             velocity_en;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] result;
  logic             zero_flag, negative_flag, carry_flag, overflow_flag, illegal;

  nav_alu_pipe #(.WIDTH(WIDTH), .ROW_W(ROW_W), .MARGIN(1), .HOLD(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .car_x(car_x), .img_row(img_row),
    .velocity_en(velocity_en), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero_flag(zero_flag), .negative_flag(negative_flag),
    .carry_flag(carry_flag), .overflow_flag(overflow_flag), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // fl = {zero, negative, carry, overflow, illegal}
  typedef struct packed {
    logic [15:0] res;
    logic [4:0]  fl;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input bit ok,
                       input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [4:0] op, input logic [15:0] ia,
                       input logic [15:0] ib, input logic [3:0] cx,
                       input logic [15:0] row, input logic [15:0] eres,
                       input logic [4:0] efl, input bit push);
    int waited;
    waited   = 0;
    opcode   = op;
    a        = ia;
    b        = ib;
    car_x    = cx;
    img_row  = row;
    in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (waited >= 100) begin
      check("issue_timeout", 1'b0, 32'(op), 32'd0);
      in_valid = 1'b0;
      return;
    end
    if (push) sb_q.push_back('{res: eres, fl: efl});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic op(input logic [4:0] o, input logic [15:0] ia,
                    input logic [15:0] ib, input logic [15:0] eres,
                    input logic [4:0] efl);
    issue(o, ia, ib, 4'd0, 16'h0000, eres, efl, 1'b1);
  endtask

  task automatic ob(input logic [3:0] cx, input logic [15:0] row,
                    input logic [15:0] eres, input logic [4:0] efl);
    issue(5'b01010, 16'h0, 16'h0, cx, row, eres, efl, 1'b1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) @(negedge clk);
    check(name, sb_q.size() == 0, 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: a transfer happens at the next posedge when valid && ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 1'b0, 32'(result), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("sb_result",
                {result, zero_flag, negative_flag, carry_flag, overflow_flag, illegal} == e,
                32'({result, zero_flag, negative_flag, carry_flag, overflow_flag, illegal}),
                32'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    check("watchdog", 1'b0, 32'd0, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    bit seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; velocity_en = 1'b0;
    opcode = '0; a = '0; b = '0; car_x = '0; img_row = '0;
    #1;
    check("rst_out_valid", out_valid == 1'b0, 32'(out_valid), 32'd0);
    check("rst_result", result == 16'h0, 32'(result), 32'd0);
    check("rst_flags",
          {zero_flag, negative_flag, carry_flag, overflow_flag, illegal} == 5'b0,
          32'({zero_flag, negative_flag, carry_flag, overflow_flag, illegal}), 32'd0);
    check("rst_in_ready", in_ready == 1'b1, 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back ADD / SUB with latency and consecutive-cycle checks
    op(5'b00011, 16'h7FFF, 16'h0001, 16'h8000, 5'b01010);
    op(5'b00100, 16'h0000, 16'h0001, 16'hFFFF, 5'b01100);
    #1;
    check("latency_add_valid", out_valid == 1'b1, 32'(out_valid), 32'd1);
    check("latency_add_result", result == 16'h8000, 32'(result), 32'h8000);
    @(negedge clk);
    #1;
    check("next_sub_valid", out_valid == 1'b1, 32'(out_valid), 32'd1);
    check("next_sub_result", result == 16'hFFFF, 32'(result), 32'hFFFF);
    @(negedge clk);

    // General-purpose ops
    op(5'b00011, 16'hFFFF, 16'h0001, 16'h0000, 5'b10100);
    op(5'b00100, 16'h8000, 16'h0001, 16'h7FFF, 5'b00010);
    op(5'b10010, 16'h0003, 16'h0005, 16'hFFFE, 5'b01100);
    op(5'b00000, 16'h1234, 16'hABCD, 16'hABCD, 5'b01000);
    op(5'b00001, 16'h1234, 16'h0000, 16'h0000, 5'b10000);
    op(5'b00010, 16'h0000, 16'h8001, 16'h8001, 5'b01000);
    op(5'b00101, 16'hF0F0, 16'hFF00, 16'hF000, 5'b01000);
    op(5'b00110, 16'h0F00, 16'h00F0, 16'h0FF0, 5'b00000);
    op(5'b00111, 16'h00FF, 16'h1111, 16'hFF00, 5'b01000);
    op(5'b01000, 16'h4321, 16'h9999, 16'h4321, 5'b00000);
    op(5'b01001, 16'h4321, 16'h9999, 16'h0000, 5'b10000);
    op(5'b10000, 16'h0003, 16'h0013, 16'h0018, 5'b00000);
    op(5'b10001, 16'h8000, 16'h000F, 16'h0001, 5'b00000);

    // Fixed action ops
    op(5'b01011, 16'h0, 16'h0, 16'h0001, 5'b00000);
    op(5'b01100, 16'h0, 16'h0, 16'h0002, 5'b00000);
    op(5'b01101, 16'h0, 16'h0, 16'h0000, 5'b10000);
    op(5'b01110, 16'h0, 16'h0, 16'h0003, 5'b00000);

    // Obstacle check
    ob(4'd5, 16'h0000, 16'h0003, 5'b00000);
    ob(4'd5, 16'h0020, 16'h0001, 5'b00000);
    ob(4'd5, 16'h0030, 16'h0002, 5'b00000);
    ob(4'd5, 16'h0070, 16'h0000, 5'b10000);
    ob(4'd0, 16'h0001, 16'h0002, 5'b00000);
    ob(4'd15, 16'h8000, 16'h0001, 5'b00000);

    // Undefined opcode
    op(5'b10101, 16'h1234, 16'h5678, 16'h0000, 5'b00001);

    // Velocity guard
    velocity_en = 1'b1;
    repeat (3) @(negedge clk);
    op(5'b01111, 16'h0, 16'h0, 16'h0000, 5'b10000);   // count 3 -> STOP
    op(5'b01111, 16'h0, 16'h0, 16'h0003, 5'b00000);   // count 4 -> CONTINUE
    velocity_en = 1'b0;                                 // falls with the accept
    op(5'b01111, 16'h0, 16'h0, 16'h0003, 5'b00000);
    velocity_en = 1'b1;                                 // after one low cycle
    op(5'b01111, 16'h0, 16'h0, 16'h0000, 5'b10000);
    drain("drain_main");

    // Backpressure: 3 ops issued under 5 stalled cycles
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        op(5'b00011, 16'h0001, 16'h0002, 16'h0003, 5'b00000);
        op(5'b00100, 16'h0005, 16'h0003, 16'h0002, 5'b00000);
        op(5'b00110, 16'h0F00, 16'h00F0, 16'h0FF0, 5'b00000);
      end
      begin
        repeat (3) @(negedge clk);
        #1;
        check("stall_in_ready", in_ready == 1'b0, 32'(in_ready), 32'd0);
        check("stall_valid", out_valid == 1'b1, 32'(out_valid), 32'd1);
        check("stall_result", result == 16'h0003, 32'(result), 32'h3);
        @(negedge clk);
        #1;
        check("stall_hold_result", result == 16'h0003, 32'(result), 32'h3);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain("drain_stall");

    // Reset with two ops in flight
    @(negedge clk);
    out_ready = 1'b0;
    issue(5'b00000, 16'h0, 16'h1111, 4'd0, 16'h0, 16'h0, 5'b0, 1'b0);
    issue(5'b00000, 16'h0, 16'h2222, 4'd0, 16'h0, 16'h0, 5'b0, 1'b0);
    #1;
    check("inflight_valid", out_valid == 1'b1, 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_valid", out_valid == 1'b0, 32'(out_valid), 32'd0);
    check("rst_async_result", result == 16'h0, 32'(result), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("rst_no_emit", seen == 1'b0, 32'(seen), 32'd0);
    check("final_queue_empty", sb_q.size() == 0, 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
